// File: rtl/led_share_pkg.sv
// led_share_pkg: shared types, widths and the Gray helper for the LED sharing controller
package led_share_pkg;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  localparam int DWELL_W = 8;
  function automatic logic [31:0] gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction
endpackage

// File: rtl/led_share_ctrl_rr_pick.sv
// rr_pick: round-robin search from ptr upward, returning a one-hot selection
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic            valid
);
  int idx;
  always_comb begin
    sel = '0;
    valid = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        sel[idx] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_share_ctrl.sv
// led_share_ctrl: round-robin sharing of the LED pins between requesters with a Gray idle animation
module led_share_ctrl
  import led_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NLED = 2,
  parameter int LOG2DELAY = 19,
  parameter int DWELL = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NLED-1:0] pat,
  output logic [NREQ-1:0]      gnt,
  output logic [NLED-1:0]      led,
  output logic                 busy
);
  localparam int PW = $clog2(NREQ);
  state_t state;
  logic [LOG2DELAY-1:0] pre;
  logic [NLED:0] cnt;
  logic [DWELL_W-1:0] dwell;
  logic [PW-1:0] ptr, nptr;
  logic [NREQ-1:0] sel;
  logic valid, tick, own_req, rivals;
  logic [NLED-1:0] sel_pat, own_pat, idle_pat;
  assign tick = &pre;
  assign idle_pat = NLED'(gray(32'(cnt)));
  assign own_req = |(req & gnt);
  assign rivals = |(req & ~gnt);
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .sel(sel),
    .valid(valid)
  );
  always_comb begin
    sel_pat = '0;
    own_pat = '0;
    nptr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_pat = sel_pat | pat[i*NLED +: NLED];
        nptr = PW'((i + 1) % NREQ);
      end
      if (gnt[i]) own_pat = own_pat | pat[i*NLED +: NLED];
    end
  end
  // A grant reloads dwell unconditionally, so a coincident tick is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      cnt <= '0;
      dwell <= '0;
      ptr <= '0;
      gnt <= '0;
      led <= '0;
      busy <= 1'b0;
    end else begin
      pre <= pre + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      case (state)
        IDLE, GAP: begin
          if (state == IDLE) led <= idle_pat;
          if (valid) begin
            gnt <= sel;
            busy <= 1'b1;
            led <= sel_pat;
            dwell <= DWELL_W'(DWELL);
            ptr <= nptr;
            state <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          led <= own_pat;
          if (dwell != '0) begin
            if (tick) dwell <= dwell - 1'b1;
          end else if (!own_req || rivals) begin
            gnt <= '0;
            busy <= 1'b0;
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
